// File: rtl/key_input_conditioner_pkg.sv
// Shared encodings, defaults and per-key event payload for the push-button conditioner.
package key_input_conditioner_pkg;

   localparam logic KC_STABLE   = 1'b0;
   localparam logic KC_COUNTING = 1'b1;

   localparam int unsigned KC_NKEYS_DEFAULT    = 4;
   localparam int unsigned KC_DEBOUNCE_DEFAULT = 500000;
   localparam int unsigned KC_CNT_W_DEFAULT    = 19;
   localparam int unsigned KC_RST_KEY_DEFAULT  = 1;
   localparam int unsigned KC_RST_HOLD_DEFAULT = 16;

   // Debounced level plus its one-cycle edge pulses for a single key.
   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
   } key_evt_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, counter debouncer and registered press/release pulses.
module key_debounce_cell
   import key_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = KC_CNT_W_DEFAULT
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     key_n,
   output key_evt_t evt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser holds raw pin polarity so its idle (released) value is 1.
   logic [1:0]       sync_q, sync_d;
   logic             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             s2;

   assign s2 = ~sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], key_n};
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         KC_STABLE: begin
            cnt_d = '0;
            if (s2 != level_q) state_d = KC_COUNTING;
         end
         KC_COUNTING: begin
            if (s2 == level_q) begin
               state_d = KC_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               level_d = s2;
               rise_d  = s2;
               fall_d  = ~s2;
               state_d = KC_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         state_q <= KC_STABLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign evt = key_evt_t'{lvl: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/key_input_conditioner.sv
// Debounces the DE1 KEY buttons and derives a stretched, registered CPU reset from one of them.
module key_input_conditioner
   import key_input_conditioner_pkg::*;
#(
   parameter int unsigned NKEYS           = KC_NKEYS_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = KC_CNT_W_DEFAULT,
   parameter int unsigned RST_KEY         = KC_RST_KEY_DEFAULT,
   parameter int unsigned RST_HOLD        = KC_RST_HOLD_DEFAULT
) (
   input  logic             CLOCK_50,
   input  logic             rst,
   input  logic [NKEYS-1:0] key_n,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic             cpu_rst
);

   localparam int unsigned      HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

   key_evt_t evt [NKEYS];

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk   (CLOCK_50),
         .rst_n (rst),
         .key_n (key_n[i]),
         .evt   (evt[i])
      );
      assign key_level[i]   = evt[i].lvl;
      assign key_press[i]   = evt[i].rise;
      assign key_release[i] = evt[i].fall;
   end

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              cpu_rst_q, cpu_rst_d;

   // Reset is held while the key is down, then for RST_HOLD cycles after it lifts.
   always_comb begin
      hold_d    = hold_q;
      cpu_rst_d = cpu_rst_q;
      if (key_level[RST_KEY]) begin
         hold_d    = HOLD_INIT;
         cpu_rst_d = 1'b1;
      end else if (hold_q != '0) begin
         hold_d    = hold_q - HOLD_W'(1);
         cpu_rst_d = 1'b1;
      end else begin
         cpu_rst_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         hold_q    <= HOLD_INIT;
         cpu_rst_q <= 1'b1;
      end else begin
         hold_q    <= hold_d;
         cpu_rst_q <= cpu_rst_d;
      end
   end

   assign cpu_rst = cpu_rst_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Randomised and directed checks of key_input_conditioner against a run-length reference model.
module tb_key_input_conditioner;

   localparam int unsigned NK = 4;
   localparam int unsigned DB = 8;
   localparam int unsigned RH = 4;
   localparam int unsigned RK = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level, key_press, key_release;
   logic          cpu_rst;

   always #5 clk = ~clk;

   key_input_conditioner #(
      .NKEYS           (NK),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (19),
      .RST_KEY         (RK),
      .RST_HOLD        (RH)
   ) dut (
      .CLOCK_50    (clk),
      .rst         (rst_n),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .cpu_rst     (cpu_rst)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference: a key's level flips once the synchronised input has disagreed with it
   // for DB+1 consecutive samples (the detecting sample plus DB counted ones).
   logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel;
   int            m_run [NK];
   int            m_age;
   logic          m_cpu;
   int            dut_press [NK];
   int            dut_rel   [NK];
   int            mod_press [NK];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
      m_age = 0;
      m_cpu = 1'b1;
   endtask

   task automatic model_edge();
      logic rk_was;
      rk_was  = m_level[RK];
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NK; i++) begin
         if (m_s2[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DB + 1) begin
               m_level[i] = m_s2[i];
               m_press[i] = m_s2[i];
               m_rel[i]   = ~m_s2[i];
               m_run[i]   = 0;
               if (m_s2[i]) mod_press[i]++;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = ~key_n;
      if (rk_was) begin
         m_age = 0;
         m_cpu = 1'b1;
      end else begin
         if (m_age < RH) m_age++;
         m_cpu = (m_age < RH);
      end
   endtask

   task automatic compare_all();
      check("key_level",   32'(key_level),   32'(m_level));
      check("key_press",   32'(key_press),   32'(m_press));
      check("key_release", 32'(key_release), 32'(m_rel));
      check("cpu_rst",     32'(cpu_rst),     32'(m_cpu));
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      compare_all();
      for (int i = 0; i < NK; i++) begin
         dut_press[i] += int'(key_press[i]);
         dut_rel[i]   += int'(key_release[i]);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      step();
      rst_n = 1'b1;
   endtask

   // Edges until the named output bit goes high (sel 0 press, 1 release), budgeted.
   task automatic wait_pulse(input int key, input int sel, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (((sel == 0) ? key_press[key] : key_release[key]) !== 1'b1 && n < 40);
   endtask

   int n, p0, r0;
   int dur [NK];

   initial begin
      for (int i = 0; i < NK; i++) begin
         dut_press[i] = 0; dut_rel[i] = 0; mod_press[i] = 0;
      end
      key_n = '1;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      step();
      step();

      // reset release with keys up: cpu_rst drops RH cycles later
      rst_n = 1'b1;
      n = 0;
      do begin step(); n++; end while (cpu_rst !== 1'b0 && n < 20);
      check("rst_release_lat", 32'(n), 32'(RH));

      // clean press on key 0
      key_n[0] = 1'b0;
      step();
      wait_pulse(0, 0, n);
      check("clean_press_lat", 32'(n), 32'(DB + 2));
      repeat (3) step();
      check("clean_level0", 32'(key_level[0]), 32'd1);
      key_n[0] = 1'b1;
      repeat (15) step();

      // bounce: low 5, high 1, then low held
      p0 = dut_press[0];
      key_n[0] = 1'b0;
      repeat (5) step();
      key_n[0] = 1'b1;
      step();
      key_n[0] = 1'b0;
      step();
      wait_pulse(0, 0, n);
      check("bounce_press_lat", 32'(n), 32'(DB + 2));
      repeat (5) step();
      check("bounce_press_cnt", 32'(dut_press[0] - p0), 32'd1);
      key_n[0] = 1'b1;
      repeat (15) step();

      // glitches on key 2 of 7, 8 and 9 cycles
      for (int len = 7; len <= 9; len++) begin
         p0 = dut_press[2];
         r0 = dut_rel[2];
         n  = mod_press[2];
         key_n[2] = 1'b0;
         repeat (len) step();
         key_n[2] = 1'b1;
         repeat (25) step();
         check("glitch_press_cnt", 32'(dut_press[2] - p0), 32'(mod_press[2] - n));
         check("glitch_rel_cnt",   32'(dut_rel[2] - r0),   32'(mod_press[2] - n));
         if (len == 7) check("glitch7_press", 32'(dut_press[2] - p0), 32'd0);
         if (len == 9) check("glitch9_press", 32'(dut_press[2] - p0), 32'd1);
      end

      // reset key held 20 cycles
      key_n[1] = 1'b0;
      repeat (20) step();
      check("rstkey_cpu_rst", 32'(cpu_rst), 32'd1);
      key_n[1] = 1'b1;
      wait_pulse(1, 1, n);
      check("rstkey_release_seen", 32'(key_release[1]), 32'd1);
      n = 0;
      do begin step(); n++; end while (cpu_rst !== 1'b0 && n < 20);
      check("rstkey_hold_lat", 32'(n), 32'(RH));

      // async reset mid-count discards the pending press
      key_n[3] = 1'b0;
      repeat (6) step();
      pulse_reset();
      step();
      wait_pulse(3, 0, n);
      check("reset_midcount_lat", 32'(n), 32'(DB + 2));
      key_n[3] = 1'b1;
      repeat (15) step();

      // randomised bouncing on all keys with occasional resets
      for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 12);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NK; i++) begin
            dur[i]--;
            if (dur[i] <= 0) begin
               key_n[i] = ~key_n[i];
               dur[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(DB, 30)
                                                     : $urandom_range(1, DB + 2);
            end
         end
         if ($urandom_range(0, 499) == 0) pulse_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
